// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: frame-tick divider, serve/play/point FSM and scores.
// Optional PONG_SPEEDUP_EN shortens the step interval as paddle hits pile up.
module pong_game_ctrl #(
   parameter int TICK_DIV    = 100,
   parameter int STEP_TICKS  = 4,
   parameter int SERVE_TICKS = 8,
   parameter int WIN_SCORE   = 7
) (
   input  logic       sys_clock,
   input  logic       reset,
   input  logic       start,
   input  logic       miss_left,
   input  logic       miss_right,
   input  logic       paddle_hit,
   output logic       tick,
   output logic       ball_load,
   output logic       serve_dir,
   output logic       ball_step,
   output logic       reset_game,
   output logic [2:0] sc1,
   output logic [2:0] sc2,
   output logic       game_over,
   output logic       winner,
   output logic [2:0] state
);

   localparam int TW = $clog2(TICK_DIV);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_POINT = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   state_t        st_q, st_d;
   logic [TW-1:0] tick_cnt;
   logic          start_q, start_rise;
   logic [7:0]    serve_cnt_q, serve_cnt_d;
   logic [2:0]    step_cnt_q, step_cnt_d;
   logic [2:0]    interval;
   logic [2:0]    sc1_d, sc2_d;
   logic          dir_d, win_d, go_d;
   logic          load_d, step_d, rg_d, hit_win;

   assign start_rise = start & ~start_q;
   assign state      = st_q;

   always_ff @(posedge sys_clock or negedge reset) begin
      if (!reset) begin
         tick_cnt <= '0;
         tick     <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         start_q <= start;
         if (tick_cnt == TW'(TICK_DIV - 1)) begin
            tick_cnt <= '0;
            tick     <= 1'b1;
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
            tick     <= 1'b0;
         end
      end
   end

`ifdef PONG_SPEEDUP_EN
   logic [4:0] hits_q;
   logic [2:0] slow;

   assign slow = hits_q[4:2];

   always_ff @(posedge sys_clock or negedge reset) begin
      if (!reset)
         hits_q <= '0;
      else if (st_d == S_SERVE && st_q != S_SERVE)
         hits_q <= '0;
      else if (st_q == S_PLAY && paddle_hit && hits_q != 5'd31)
         hits_q <= hits_q + 5'd1;
   end

   always_comb begin
      interval = 3'd1;
      if (32'(slow) < 32'(STEP_TICKS))
         interval = 3'(STEP_TICKS) - slow;
   end
`else
   logic unused_hit;

   assign unused_hit = paddle_hit;
   assign interval   = 3'(STEP_TICKS);
`endif

   always_comb begin
      st_d        = st_q;
      serve_cnt_d = serve_cnt_q;
      step_cnt_d  = step_cnt_q;
      sc1_d       = sc1;
      sc2_d       = sc2;
      dir_d       = serve_dir;
      win_d       = winner;
      go_d        = game_over;
      load_d      = 1'b0;
      step_d      = 1'b0;
      rg_d        = 1'b0;
      hit_win     = 1'b0;
      unique case (st_q)
         S_IDLE, S_OVER: begin
            if (start_rise) begin
               st_d        = S_SERVE;
               sc1_d       = '0;
               sc2_d       = '0;
               dir_d       = 1'b0;
               win_d       = 1'b0;
               go_d        = 1'b0;
               rg_d        = 1'b1;
               load_d      = 1'b1;
               serve_cnt_d = '0;
            end
         end
         S_SERVE: begin
            if (tick) begin
               if (serve_cnt_q == 8'(SERVE_TICKS - 1)) begin
                  st_d        = S_PLAY;
                  serve_cnt_d = '0;
                  step_cnt_d  = '0;
               end else begin
                  serve_cnt_d = serve_cnt_q + 8'd1;
               end
            end
         end
         S_PLAY: begin
            if (miss_left) begin
               st_d  = S_POINT;
               dir_d = 1'b0;
            end else if (miss_right) begin
               st_d  = S_POINT;
               dir_d = 1'b1;
            end else if (tick) begin
               if ({1'b0, step_cnt_q} + 4'd1 >= {1'b0, interval}) begin
                  step_d     = 1'b1;
                  step_cnt_d = '0;
               end else begin
                  step_cnt_d = step_cnt_q + 3'd1;
               end
            end
         end
         S_POINT: begin
            // serve_dir already points at the loser: 0 means P2 scored
            if (!serve_dir) begin
               sc2_d   = (sc2 == 3'd7) ? sc2 : sc2 + 3'd1;
               hit_win = (sc2_d == 3'(WIN_SCORE));
            end else begin
               sc1_d   = (sc1 == 3'd7) ? sc1 : sc1 + 3'd1;
               hit_win = (sc1_d == 3'(WIN_SCORE));
            end
            if (hit_win) begin
               st_d  = S_OVER;
               go_d  = 1'b1;
               win_d = ~serve_dir;
            end else begin
               st_d        = S_SERVE;
               load_d      = 1'b1;
               serve_cnt_d = '0;
            end
         end
         default: st_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clock or negedge reset) begin
      if (!reset) begin
         st_q        <= S_IDLE;
         serve_cnt_q <= '0;
         step_cnt_q  <= '0;
         sc1         <= '0;
         sc2         <= '0;
         serve_dir   <= 1'b0;
         winner      <= 1'b0;
         game_over   <= 1'b0;
         ball_load   <= 1'b0;
         ball_step   <= 1'b0;
         reset_game  <= 1'b0;
      end else begin
         st_q        <= st_d;
         serve_cnt_q <= serve_cnt_d;
         step_cnt_q  <= step_cnt_d;
         sc1         <= sc1_d;
         sc2         <= sc2_d;
         serve_dir   <= dir_d;
         winner      <= win_d;
         game_over   <= go_d;
         ball_load   <= load_d;
         ball_step   <= step_d;
         reset_game  <= rg_d;
      end
   end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: table of game events plus timing,
// coincidence and mid-game reset sequences.
module tb_pong_game_ctrl;

   localparam int TD  = 4;
   localparam int STP = 4;
   localparam int SRV = 2;
   localparam int WIN = 3;

   localparam int IDLE  = 0;
   localparam int SERVE = 1;
   localparam int PLAY  = 2;
   localparam int POINT = 3;
   localparam int OVER  = 4;

   localparam int A_ML    = 0;
   localparam int A_MR    = 1;
   localparam int A_MB    = 2;
   localparam int A_MLX   = 3;
   localparam int A_MRX   = 4;
   localparam int A_START = 5;

   logic       sys_clock  = 1'b0;
   logic       reset      = 1'b0;
   logic       start      = 1'b0;
   logic       miss_left  = 1'b0;
   logic       miss_right = 1'b0;
   logic       paddle_hit = 1'b0;
   logic       tick, ball_load, serve_dir, ball_step, reset_game;
   logic [2:0] sc1, sc2, state;
   logic       game_over, winner;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string name;
      int    act;
      int    st;
      int    s1;
      int    s2;
      int    dir;
      int    go;
      int    win;
   } vec_t;

   vec_t tbl[7];

   pong_game_ctrl #(
      .TICK_DIV   (TD),
      .STEP_TICKS (STP),
      .SERVE_TICKS(SRV),
      .WIN_SCORE  (WIN)
   ) dut (
      .sys_clock (sys_clock),
      .reset     (reset),
      .start     (start),
      .miss_left (miss_left),
      .miss_right(miss_right),
      .paddle_hit(paddle_hit),
      .tick      (tick),
      .ball_load (ball_load),
      .serve_dir (serve_dir),
      .ball_step (ball_step),
      .reset_game(reset_game),
      .sc1       (sc1),
      .sc2       (sc2),
      .game_over (game_over),
      .winner    (winner),
      .state     (state)
   );

   always #5 sys_clock = ~sys_clock;

   function automatic vec_t mk(input string nm, input int a, input int st,
                               input int s1, input int s2, input int d,
                               input int go, input int w);
      vec_t v;
      v.name = nm; v.act = a; v.st = st; v.s1 = s1;
      v.s2 = s2; v.dir = d; v.go = go; v.win = w;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic wait_state(input int s, input int max);
      int n = 0;
      while (int'(state) != s && n < max) begin
         @(negedge sys_clock);
         n++;
      end
      if (int'(state) != s) chk("wait_state timeout", int'(state), s);
   endtask

   task automatic wait_step(input int max, output int n);
      n = 0;
      do begin
         @(negedge sys_clock);
         n++;
      end while (!ball_step && n < max);
      if (!ball_step) chk("wait_step timeout", 0, 1);
   endtask

   task automatic pulse_miss(input logic l, input logic r);
      miss_left  = l;
      miss_right = r;
      @(posedge sys_clock);
      @(negedge sys_clock);
      miss_left  = 1'b0;
      miss_right = 1'b0;
   endtask

   initial begin
      int n;
      int cnt;

      tbl[0] = mk("mr1",    A_MR,    SERVE, 1, 0, 1, 0, 0);
      tbl[1] = mk("ml1",    A_ML,    SERVE, 1, 1, 0, 0, 0);
      tbl[2] = mk("both",   A_MB,    SERVE, 1, 2, 0, 0, 0);
      tbl[3] = mk("win",    A_ML,    OVER,  1, 3, 0, 1, 1);
      tbl[4] = mk("ovr_ml", A_MLX,   OVER,  1, 3, 0, 1, 1);
      tbl[5] = mk("ovr_mr", A_MRX,   OVER,  1, 3, 0, 1, 1);
      tbl[6] = mk("restart",A_START, SERVE, 0, 0, 0, 0, 0);

      // reset state
      repeat (3) @(negedge sys_clock);
      chk("rst.state", state, IDLE);
      chk("rst.sc1", sc1, 0);
      chk("rst.sc2", sc2, 0);
      chk("rst.tick", tick, 0);
      chk("rst.load", ball_load, 0);
      chk("rst.step", ball_step, 0);
      chk("rst.rg", reset_game, 0);
      chk("rst.go", game_over, 0);
      chk("rst.dir", serve_dir, 0);
      reset = 1'b1;

      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge sys_clock);
         if (tick) cnt++;
      end
      chk("tick_count", cnt, 10);
      chk("idle_hold", state, IDLE);

      // align the start so the first counted tick lands 4 cycles in
      n = 0;
      while (!tick && n < 10) begin
         @(negedge sys_clock);
         n++;
      end
      chk("tick_seen", tick, 1);
      start = 1'b1;
      @(posedge sys_clock);
      @(negedge sys_clock);
      start = 1'b0;
      chk("start.state", state, SERVE);
      chk("start.rg", reset_game, 1);
      chk("start.load", ball_load, 1);
      chk("start.sc1", sc1, 0);
      @(negedge sys_clock);
      chk("start.rg_len", reset_game, 0);
      chk("start.load_len", ball_load, 0);
      n = 1;
      while (int'(state) != PLAY && n < 50) begin
         @(negedge sys_clock);
         n++;
      end
      chk("serve_len", n, SRV * TD);

      wait_step(100, n);
      chk("first_step", n, STP * TD);
      @(negedge sys_clock);
      chk("step_len", ball_step, 0);
      wait_step(100, n);
      chk("step_spacing", n + 1, STP * TD);

      // event table
      for (int i = 0; i < 7; i++) begin
         case (tbl[i].act)
            A_START: begin
               start = 1'b1;
               @(posedge sys_clock);
               @(negedge sys_clock);
               start = 1'b0;
               chk($sformatf("%s.rg", tbl[i].name), reset_game, 1);
            end
            A_MLX, A_MRX: begin
               pulse_miss(tbl[i].act == A_MLX, tbl[i].act == A_MRX);
               @(negedge sys_clock);
            end
            default: begin
               wait_state(PLAY, 100);
               pulse_miss(tbl[i].act != A_MR, tbl[i].act != A_ML);
               chk($sformatf("%s.point", tbl[i].name), state, POINT);
               @(negedge sys_clock);
            end
         endcase
         chk($sformatf("%s.state", tbl[i].name), state, tbl[i].st);
         chk($sformatf("%s.sc1", tbl[i].name), sc1, tbl[i].s1);
         chk($sformatf("%s.sc2", tbl[i].name), sc2, tbl[i].s2);
         chk($sformatf("%s.dir", tbl[i].name), serve_dir, tbl[i].dir);
         chk($sformatf("%s.go", tbl[i].name), game_over, tbl[i].go);
         chk($sformatf("%s.load", tbl[i].name), ball_load,
             (tbl[i].st == SERVE) ? 1 : 0);
         if (tbl[i].go == 1)
            chk($sformatf("%s.win", tbl[i].name), winner, tbl[i].win);
      end

      // miss on the same edge a step would be issued
      wait_step(200, n);
      repeat (STP * TD - 1) @(negedge sys_clock);
      miss_left = 1'b1;
      @(posedge sys_clock);
      @(negedge sys_clock);
      miss_left = 1'b0;
      chk("coinc.step", ball_step, 0);
      chk("coinc.state", state, POINT);
      @(negedge sys_clock);
      chk("coinc.sc2", sc2, 1);

      // reach PLAY with sc1=2, then reset asynchronously
      for (int k = 0; k < 2; k++) begin
         wait_state(PLAY, 100);
         pulse_miss(1'b0, 1'b1);
         @(negedge sys_clock);
      end
      wait_state(PLAY, 100);
      chk("pre_rst.sc1", sc1, 2);
      chk("pre_rst.dir", serve_dir, 1);
      #1 reset = 1'b0;
      #1;
      chk("mid_rst.state", state, IDLE);
      chk("mid_rst.sc1", sc1, 0);
      chk("mid_rst.sc2", sc2, 0);
      chk("mid_rst.dir", serve_dir, 0);
      chk("mid_rst.strobes",
          int'({tick, ball_load, ball_step, reset_game, game_over, winner}), 0);

      start = 1'b1;
      @(negedge sys_clock);
      reset = 1'b1;
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge sys_clock);
         if (reset_game) cnt++;
      end
      chk("hold_start.rg", cnt, 1);
      chk("hold_start.active", int'(state == 3'(IDLE)), 0);
      start = 1'b0;

`ifdef PONG_SPEEDUP_EN
      wait_state(PLAY, 100);
      paddle_hit = 1'b1;
      repeat (8) @(negedge sys_clock);
      paddle_hit = 1'b0;
      wait_step(200, n);
      wait_step(200, n);
      chk("speed.fast", n, 2 * TD);
      pulse_miss(1'b1, 1'b0);
      wait_state(PLAY, 100);
      wait_step(200, n);
      wait_step(200, n);
      chk("speed.reset", n, STP * TD);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game sequencer for the Pong design: a free-running frame-tick divider plus the game-state machine that decides when the ball moves, when it is re-served, and when the game ends. Sits between the collision detector, which reports misses and paddle hits, and the ball-movement block, which it drives with serve/step strobes. Owns the two score registers and the `reset_game` pulse consumed by paddle movement and the LED renderer.

## Interface
- `TICK_DIV`, 100: `sys_clock` cycles per frame tick; ≥2.
- `STEP_TICKS`, 4: frame ticks per ball step at base speed; range 1..7.
- `SERVE_TICKS`, 8: frame ticks spent in SERVE before play; range 1..255.
- `WIN_SCORE`, 7: points needed to win; range 1..7.

Ports:
- `sys_clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: start button, level, synchronous to `sys_clock`.
- `miss_left` in 1: ball passed the P1 paddle; single-cycle pulse.
- `miss_right` in 1: ball passed the P2 paddle; single-cycle pulse.
- `paddle_hit` in 1: ball bounced off either paddle; single-cycle pulse.
- `tick` out 1: frame-tick strobe, high one cycle every `TICK_DIV` cycles.
- `ball_load` out 1: one-cycle strobe; ball block recentres the ball.
- `serve_dir` out 1: 0 = serve toward P1 (left), 1 = toward P2 (right); valid while `ball_load` is high.
- `ball_step` out 1: one-cycle strobe; ball block advances one position.
- `reset_game` out 1: one-cycle pulse on game start.
- `sc1` out 3: P1 score.
- `sc2` out 3: P2 score.
- `game_over` out 1: high in OVER.
- `winner` out 1: 0 = P1, 1 = P2; valid while `game_over` is high.
- `state` out 3: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.

## Operation
- All outputs are registered. Reset values: `state`=IDLE, every strobe 0, `sc1`=`sc2`=0, `serve_dir`=0, `winner`=0, `game_over`=0. Tick, step and serve counters reset to 0.
- Tick divider: counts 0..`TICK_DIV`-1 and wraps. `tick` fires on the wrap. Runs in every state.
- Start edge: `start_rise` = `start` & ~`start_q`, where `start_q` is `start` delayed one cycle.
- IDLE: on `start_rise`, clear both scores, pulse `reset_game`, set `serve_dir`=0, go to SERVE.
- SERVE: `ball_load` is high in the first cycle of SERVE. After `SERVE_TICKS` ticks, go to PLAY and clear the step counter.
- PLAY: count ticks. When the count reaches the current interval, pulse `ball_step` and clear the count.
  - `miss_left`: P2 scores, `serve_dir`=0, go to POINT.
  - `miss_right`: P1 scores, `serve_dir`=1, go to POINT.
  - Both in the same cycle: `miss_left` wins and `miss_right` is dropped.
  - A miss in the same cycle as a step: the miss wins and no `ball_step` is issued.
- POINT (one cycle): increment the scoring player's score. If the new score equals `WIN_SCORE`, set `winner` and go to OVER; otherwise go to SERVE. Scores saturate at 7.
- OVER: `game_over`=1 and scores are held. On `start_rise`, behave exactly as the IDLE start (clear, `reset_game`, SERVE).
- `miss_*` and `paddle_hit` outside PLAY are ignored. `start` outside IDLE/OVER is ignored.
- Asserting `reset` mid-game returns every output to its reset value immediately, with no strobe emitted.

## Timing
- `start_rise` sampled at edge N: `state`=SERVE, `reset_game`=1 and scores=0 after edge N. `ball_load`=1 for the cycle following edge N.
- SERVE→PLAY: on the edge of the `SERVE_TICKS`-th tick counted in SERVE.
- `ball_step`: rises the cycle after the qualifying `tick`. Spacing is exactly interval × `TICK_DIV` cycles.
- Miss pulse at edge N: POINT after N, scores updated after N+1, SERVE/OVER after N+1, `ball_load` during the cycle after N+1.

## Configuration
- `PONG_SPEEDUP_EN` defined: a 5-bit hit counter increments on `paddle_hit` in PLAY (saturating) and clears on SERVE entry.
  - Step interval = max(1, `STEP_TICKS` − hits/4).
  - A change in interval takes effect at the next step-count comparison.
- `PONG_SPEEDUP_EN` undefined: interval is fixed at `STEP_TICKS`. `paddle_hit` is unused and there is no hit counter.

## Test plan
- Reset/start, `TICK_DIV`=4, `SERVE_TICKS`=2: release reset, pulse `start` → `reset_game` and `ball_load` one cycle each; PLAY entered 8 cycles after SERVE entry; `ball_step` every 16 cycles.
- Scoring: in PLAY, pulse `miss_right` → `sc1`=1, `serve_dir`=1, return to SERVE with `ball_load`. Then pulse `miss_left` → `sc2`=1, `serve_dir`=0.
- Win, `WIN_SCORE`=3: three `miss_left` pulses → `sc2`=3, `game_over`=1, `winner`=1. Further misses leave scores unchanged. `start` → scores 0, SERVE.
- Simultaneous events: `miss_left`+`miss_right` in the same cycle → only `sc2` increments. Miss coincident with a step → no `ball_step`.
- Reset mid-PLAY with `sc1`=2: assert `reset` → all outputs 0 and IDLE immediately. Holding `start` high produces only one `start_rise`.
- `PONG_SPEEDUP_EN`: 8 `paddle_hit` pulses, `STEP_TICKS`=4 → step interval drops to 2 ticks; after a miss and re-serve it is back to 4.
